// File: rtl/vec_player_capture.sv
// ---------------------------------------------------------------------------
// vec_player_capture
//
// Stimulus/response engine for combinational benchmark circuits (ISCAS85
// c17, c432, ...). Vectors are loaded into an internal memory while idle.
// A run applies each vector to the DUT and waits SETTLE_CYC cycles. It then
// captures the DUT response and folds it into a MISR signature. A run is
// either a single pass, a continuous loop (ended by stop), or single-step
// (one vector per step pulse).
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   load_en    vector memory write strobe (honoured only while idle)
//   load_addr  vector memory write address
//   load_data  vector memory write data
//   vec_len    vectors per pass, sampled at start
//   mode       0 single, 1 loop, 2 step, 3 treated as single; sampled at start
//   start      begin a run (pulse, ignored while busy)
//   stop       end a loop/step run after the current vector
//   step       advance one vector in step mode
//   dut_in     registered stimulus to the DUT
//   dut_out    DUT response
//   cap_valid  one-cycle pulse, cap_data/cap_idx valid
//   cap_data   captured response
//   cap_idx    index of the captured vector
//   signature  running MISR value
//   busy       high whenever the engine is not idle
//   done       one-cycle pulse at the end of a run
//   pass_cnt   completed full passes, saturating
// ---------------------------------------------------------------------------
module vec_player_capture #(
    parameter int               IN_W       = 36,
    parameter int               OUT_W      = 7,
    parameter int               DEPTH      = 32,
    parameter int               ADDR_W     = 5,
    parameter int               SETTLE_CYC = 1,
    parameter logic [OUT_W-1:0] MISR_POLY  = 7'h03,
    parameter logic [OUT_W-1:0] MISR_SEED  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [IN_W-1:0]   load_data,
    input  logic [ADDR_W:0]   vec_len,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              cap_valid,
    output logic [OUT_W-1:0]  cap_data,
    output logic [ADDR_W-1:0] cap_idx,
    output logic [OUT_W-1:0]  signature,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_PAUSE,
        S_FINISH
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_LOOP   = 2'd1;
    localparam logic [1:0] MODE_STEP   = 2'd2;

    localparam int unsigned     DEPTH_U    = DEPTH;
    localparam int              SC_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = 1;

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                   input logic [OUT_W-1:0] d);
        return (s << 1) ^ (s[OUT_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [IN_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   vec_len_q, vec_len_d;
    logic [1:0]        mode_q, mode_d;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic              stop_seen_q, stop_seen_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic              cap_valid_q, cap_valid_d;
    logic [OUT_W-1:0]  cap_data_q, cap_data_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
    logic [OUT_W-1:0]  sig_q, sig_d;
    logic              done_q, done_d;
    logic [15:0]       pass_q, pass_d;

    logic              addr_ok;
    logic              len_bad;
    logic              is_last;
    logic [ADDR_W-1:0] idx_wrap;

    assign addr_ok  = (32'(load_addr) < DEPTH_U);
    // Length is validated on the latched copy, so an empty or oversized run
    // spends one cycle in APPLY before heading to FINISH.
    assign len_bad  = (vec_len_q == '0) || (32'(vec_len_q) > DEPTH_U);
    assign is_last  = ({1'b0, idx_q} == (vec_len_q - LEN_ONE));
    assign idx_wrap = is_last ? '0 : idx_q + IDX_ONE;

    // Memory is writable only while idle; it is never reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && load_en && addr_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_len_d   = vec_len_q;
        mode_d      = mode_q;
        settle_d    = settle_q;
        stop_seen_d = stop_seen_q;
        dut_in_d    = dut_in_q;
        cap_valid_d = 1'b0;
        cap_data_d  = cap_data_q;
        cap_idx_d   = cap_idx_q;
        sig_d       = sig_q;
        done_d      = 1'b0;
        pass_d      = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_len_d   = vec_len;
                    mode_d      = (mode == 2'd3) ? MODE_SINGLE : mode;
                    idx_d       = '0;
                    sig_d       = MISR_SEED;
                    pass_d      = '0;
                    stop_seen_d = 1'b0;
                    state_d     = S_APPLY;
                end
            end
            S_APPLY: begin
                if (stop) stop_seen_d = 1'b1;
                if (len_bad) begin
                    state_d = S_FINISH;
                end else begin
                    dut_in_d = mem[idx_q];
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (stop) stop_seen_d = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                cap_valid_d = 1'b1;
                cap_data_d  = dut_out;
                cap_idx_d   = idx_q;
                sig_d       = misr_step(sig_q, dut_out);
                stop_seen_d = 1'b0;
                if (is_last) pass_d = sat_inc16(pass_q);
                case (mode_q)
                    MODE_LOOP: begin
                        idx_d   = idx_wrap;
                        // A stop seen at any point of this vector, including
                        // the capture cycle itself, ends the run here.
                        state_d = (stop_seen_q || stop) ? S_FINISH : S_APPLY;
                    end
                    MODE_STEP: begin
                        idx_d   = idx_wrap;
                        state_d = S_PAUSE;
                    end
                    default: begin
                        if (is_last) begin
                            state_d = S_FINISH;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = S_APPLY;
                        end
                    end
                endcase
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_FINISH;
                end else if (step) begin
                    state_d = S_APPLY;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            vec_len_q   <= '0;
            mode_q      <= MODE_SINGLE;
            settle_q    <= '0;
            stop_seen_q <= 1'b0;
            dut_in_q    <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            cap_idx_q   <= '0;
            sig_q       <= MISR_SEED;
            done_q      <= 1'b0;
            pass_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_len_q   <= vec_len_d;
            mode_q      <= mode_d;
            settle_q    <= settle_d;
            stop_seen_q <= stop_seen_d;
            dut_in_q    <= dut_in_d;
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
            cap_idx_q   <= cap_idx_d;
            sig_q       <= sig_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign cap_valid = cap_valid_q;
    assign cap_data  = cap_data_q;
    assign cap_idx   = cap_idx_q;
    assign signature = sig_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign pass_cnt  = pass_q;

endmodule
